ifu_fetch: RTL

- Instruction fetch stage that sits directly upstream of the single-cycle RV32 execute core.
- Owns the fetch PC and issues word reads to instruction memory over a valid/ready request channel.
- Buffers returned words in a small in-order FIFO and presents {inst, inst_pc} to decode over a valid/ready handshake.
- Handles redirects from jal/jalr resolution by flushing buffered words and discarding in-flight responses.

---
 rtl/ifu_fetch.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : ifu_fetch
// Desc    : RV32 instruction fetch stage with credit-limited requests, an
//           in-order instruction FIFO and redirect flush. Macro IFU_PERF_EN
//           enables the saturating decode-stall cycle counter.
// Rev     : 1.0
// ============================================================================
module ifu_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter int          CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             req_valid,
   input  logic             req_ready,
   output logic [31:0]      req_addr,
   input  logic             rsp_valid,
   input  logic [31:0]      rsp_data,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst,
   output logic [31:0]      inst_pc,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] perf_stall_cnt
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W:0] c_DEPTH_EXT = (c_CNT_W + 1)'(FIFO_DEPTH);

   logic [31:0]        r_fetch_pc;
   logic [c_CNT_W-1:0] r_outstanding;
   logic [c_CNT_W-1:0] r_drop_cnt;

   logic [31:0]        r_tag [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_tag_wptr;
   logic [c_PTR_W-1:0] r_tag_rptr;

   logic [31:0]        r_fifo_inst [FIFO_DEPTH];
   logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_fifo_wptr;
   logic [c_PTR_W-1:0] r_fifo_rptr;
   logic [c_CNT_W-1:0] r_fifo_cnt;

   logic [c_CNT_W:0]   w_credit_sum;
   logic               w_accept;
   logic               w_dropping;
   logic               w_push;
   logic               w_pop;
   logic               w_unused;

   // Credits cover both buffered and in-flight words, so a response always has a slot.
   assign w_credit_sum = {1'b0, r_fifo_cnt} + {1'b0, r_outstanding};
   assign req_valid    = reset & ~redirect_valid & (r_drop_cnt == '0)
                         & (w_credit_sum < c_DEPTH_EXT);
   assign req_addr     = r_fetch_pc;
   assign w_accept     = req_valid & req_ready;
   assign w_dropping   = (r_drop_cnt != '0);
   assign w_push       = rsp_valid & ~w_dropping & ~redirect_valid;
   assign w_pop        = inst_valid & inst_ready & ~redirect_valid;

   assign inst_valid   = (r_fifo_cnt != '0);
   assign inst         = r_fifo_inst[r_fifo_rptr];
   assign inst_pc      = r_fifo_pc[r_fifo_rptr];
   assign w_unused     = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_accept) begin
         r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_outstanding <= '0;
      end else if (w_accept && !rsp_valid) begin
         r_outstanding <= r_outstanding + c_CNT_W'(1);
      end else if (!w_accept && rsp_valid) begin
         r_outstanding <= r_outstanding - c_CNT_W'(1);
      end
   end

   // A response in the redirect cycle is already discarded, so it is not counted again.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_drop_cnt <= '0;
      end else if (redirect_valid) begin
         r_drop_cnt <= r_outstanding - c_CNT_W'(rsp_valid);
      end else if (rsp_valid && w_dropping) begin
         r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_tag[i] <= '0;
         end
         r_tag_wptr <= '0;
         r_tag_rptr <= '0;
      end else begin
         if (w_accept) begin
            r_tag[r_tag_wptr] <= r_fetch_pc;
            r_tag_wptr        <= r_tag_wptr + c_PTR_W'(1);
         end
         if (rsp_valid) begin
            r_tag_rptr <= r_tag_rptr + c_PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fifo_wptr <= '0;
         r_fifo_rptr <= '0;
         r_fifo_cnt  <= '0;
      end else if (redirect_valid) begin
         r_fifo_rptr <= r_fifo_wptr;
         r_fifo_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_fifo_wptr <= r_fifo_wptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_fifo_rptr <= r_fifo_rptr + c_PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_inst[i] <= '0;
            r_fifo_pc[i]   <= '0;
         end
      end else if (w_push) begin
         r_fifo_inst[r_fifo_wptr] <= rsp_data;
         r_fifo_pc[r_fifo_wptr]   <= r_tag[r_tag_rptr];
      end
   end

`ifdef IFU_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (!inst_valid && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign perf_stall_cnt = r_stall_cnt;
`else
   assign perf_stall_cnt = '0;
`endif

endmodule
`default_nettype wire
